// File: rtl/debouncer_multi_if.sv
// Pin-side bundle of the multi-channel debouncer: raw inputs plus debounced level and strobes.
// master drives the raw pins, slave is the debouncer itself.
interface debouncer_multi_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] btn_out;
    logic [CHANNELS-1:0] btn_rise;
    logic [CHANNELS-1:0] btn_fall;
    logic [CHANNELS-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_out,
        input  btn_rise,
        input  btn_fall,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_out,
        output btn_rise,
        output btn_fall,
        output btn_repeat
    );
endinterface

// File: rtl/debouncer_multi.sv
// CHANNELS independent debouncers: 2-flop sync, stability counter, registered rise/fall strobes.
// Optional auto-repeat strobes while held are built only when DEBOUNCER_REPEAT_EN is defined.
module debouncer_multi #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned DEBOUNCE_COUNT = 12_500_000,
    parameter int unsigned CNT_WIDTH      = 24,
    parameter logic        RESET_LEVEL    = 1'b0,
    parameter int unsigned REPEAT_DELAY   = 50_000_000,
    parameter int unsigned REPEAT_PERIOD  = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    debouncer_multi_if.slave  bus
);

    if (CHANNELS < 1 || DEBOUNCE_COUNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("debouncer_multi: CHANNELS, DEBOUNCE_COUNT and REPEAT_* must all be >= 1");
    end
    if ((64'd1 << CNT_WIDTH) <= 64'(DEBOUNCE_COUNT) - 64'd1) begin : g_bad_width
        $error("debouncer_multi: CNT_WIDTH too small for DEBOUNCE_COUNT");
    end

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] mismatch, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign mismatch = sync2_q ^ out_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

        assign accept[i] = mismatch[i] && (cnt_q == CntLast);

        // Any matching sample restarts the count; acceptance also clears it so it never wraps.
        always_comb begin
            cnt_d = cnt_q + 1'b1;
            if (!mismatch[i] || accept[i]) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign out_d  = out_q ^ accept;
    assign rise_d = accept & sync2_q;
    assign fall_d = accept & ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= {CHANNELS{RESET_LEVEL}};
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.btn_out  = out_q;
    assign bus.btn_rise = rise_q;
    assign bus.btn_fall = fall_q;

`ifdef DEBOUNCER_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;
    localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

    logic [CHANNELS-1:0] rep_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_rpt
        rpt_state_e     st_q, st_d;
        logic [RptW-1:0] rcnt_q, rcnt_d;
        logic           rep_q, rep_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= StIdle;
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                rcnt_q <= rcnt_d;
                rep_q  <= rep_d;
            end
        end

        // Driven from rise_d/fall_d so the FSM moves in step with the registered strobes:
        // rcnt_q equals the cycle number counted from the btn_rise cycle.
        always_comb begin
            st_d   = st_q;
            rcnt_d = rcnt_q;
            if (fall_d[i]) begin
                st_d   = StIdle;
                rcnt_d = '0;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        if (rise_d[i]) begin
                            st_d   = StDelay;
                            rcnt_d = '0;
                        end
                    end
                    StDelay: begin
                        if (rcnt_q == DelayLast) begin
                            st_d   = StRepeat;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (rcnt_q == PeriodLast) begin
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        st_d   = StIdle;
                        rcnt_d = '0;
                    end
                endcase
            end
        end

        always_comb begin
            rep_d = 1'b0;
            if (!fall_d[i]) begin
                rep_d = ((st_q == StDelay) && (rcnt_q == DelayLast)) ||
                        ((st_q == StRepeat) && (rcnt_q == PeriodLast));
            end
        end

        assign rep_vec[i] = rep_q;
    end

    assign bus.btn_repeat = rep_vec;
`else
    assign bus.btn_repeat = '0;
`endif

endmodule
